// File: rtl/xadc_packet_package.sv
// Shared types and helpers for the multichannel XADC COBS packetizer.
package xadc_packet_package;

  localparam logic [7:0] COBS_DELIMITER = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    CAPTURE,
    SERIALIZE,
    FINALIZE,
    EMIT,
    DELIM
  } pkt_state_t;

  function automatic int sample_bytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/cobs_encode_buffer.sv
// Byte buffer that COBS-encodes a payload in place: slot 0 holds the overhead
// code and payload byte k lands in slot k+1 unless it is a zero.
module cobs_encode_buffer
  import xadc_packet_package::*;
#(
  parameter int BUF_DEPTH = 64,
  parameter int ADDR_W    = $clog2(BUF_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_index,
  input  logic [7:0]        wr_data,
  input  logic              fin_en,
  input  logic [ADDR_W-1:0] fin_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0]        mem [BUF_DEPTH];
  logic [ADDR_W-1:0] last_code_pos;
  logic [ADDR_W-1:0] slot;

  assign slot    = wr_index + ADDR_W'(1);
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_code_pos <= '0;
    end else if (clear) begin
      last_code_pos <= '0;
    end else if (wr_en && wr_data == COBS_DELIMITER) begin
      last_code_pos <= slot;
    end
  end

  // A zero byte closes the current block: its code slot gets the distance to here.
  always_ff @(posedge clk) begin
    if (fin_en) begin
      mem[last_code_pos] <= 8'(fin_len + ADDR_W'(1) - last_code_pos);
    end else if (wr_en) begin
      if (wr_data == COBS_DELIMITER) begin
        mem[last_code_pos] <= 8'(slot - last_code_pos);
      end else begin
        mem[slot] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/xadc_multichannel_packetizer.sv
// Collects one sample per enabled channel, frames it with seq/mask bytes,
// COBS-encodes it and streams it out as bytes ending in a 0x00 delimiter.
module xadc_multichannel_packetizer
  import xadc_packet_package::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int SAMPLE_WIDTH = 16,
  parameter int BUF_DEPTH    = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CHANNELS-1:0]              channel_enable,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] ch_tdata,
  input  logic [NUM_CHANNELS-1:0]              ch_tvalid,
  output logic [NUM_CHANNELS-1:0]              ch_tready,
  output logic [7:0]                           pkt_tdata,
  output logic                                 pkt_tvalid,
  input  logic                                 pkt_tready,
  output logic                                 pkt_tlast,
  output logic [7:0]                           seq_count
);

  localparam int SB  = sample_bytes(SAMPLE_WIDTH);
  localparam int AW  = $clog2(BUF_DEPTH);
  localparam int CW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int BCW = (SB > 1) ? $clog2(SB) : 1;

  generate
    if (BUF_DEPTH < 3 + NUM_CHANNELS * SB) begin : g_depth_check
      $error("BUF_DEPTH too small for NUM_CHANNELS samples");
    end
  endgenerate

  pkt_state_t state, state_next;

  logic [NUM_CHANNELS-1:0] mask;
  logic [7:0]              mask_byte;
  logic [CW-1:0]           cur, first_ch, next_ch;
  logic                    has_next;
  logic [BCW-1:0]          byte_cnt;
  logic [SB*8-1:0]         sample_reg;
  logic [AW-1:0]           pay_idx, len, rd_ptr;
  logic                    wr_en, fin_en, buf_clear, out_load;
  logic [7:0]              wr_data, rd_data;

  assign out_load = !pkt_tvalid || pkt_tready;

  always_comb begin
    mask_byte = '0;
    mask_byte[NUM_CHANNELS-1:0] = mask;
  end

  // Lowest channel in the incoming enable, and the next latched channel above cur.
  always_comb begin
    first_ch = '0;
    has_next = 1'b0;
    next_ch  = cur;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (channel_enable[i]) first_ch = CW'(i);
      if (mask[i] && i > int'(cur)) begin
        has_next = 1'b1;
        next_ch  = CW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ch_tready  = '0;
    wr_en      = 1'b0;
    wr_data    = seq_count;
    fin_en     = 1'b0;
    buf_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (|channel_enable) begin
          buf_clear  = 1'b1;
          state_next = HEADER;
        end
      end
      HEADER: begin
        wr_en   = 1'b1;
        wr_data = (byte_cnt == '0) ? seq_count : mask_byte;
        if (byte_cnt == BCW'(1)) state_next = CAPTURE;
      end
      CAPTURE: begin
        ch_tready[cur] = 1'b1;
        if (ch_tvalid[cur]) state_next = SERIALIZE;
      end
      SERIALIZE: begin
        wr_en   = 1'b1;
        wr_data = sample_reg[7:0];
        if (byte_cnt == BCW'(SB - 1)) state_next = has_next ? CAPTURE : FINALIZE;
      end
      FINALIZE: begin
        fin_en     = 1'b1;
        state_next = EMIT;
      end
      EMIT: begin
        if (out_load && rd_ptr > len) state_next = DELIM;
      end
      DELIM: begin
        if (pkt_tready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered output stage; output regs only move when out_load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask       <= '0;
      cur        <= '0;
      byte_cnt   <= '0;
      sample_reg <= '0;
      pay_idx    <= '0;
      len        <= '0;
      rd_ptr     <= '0;
      pkt_tdata  <= '0;
      pkt_tvalid <= 1'b0;
      pkt_tlast  <= 1'b0;
      seq_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          mask     <= channel_enable;
          cur      <= first_ch;
          byte_cnt <= '0;
          pay_idx  <= '0;
        end
        HEADER: begin
          pay_idx  <= pay_idx + AW'(1);
          byte_cnt <= (byte_cnt == BCW'(1)) ? '0 : byte_cnt + BCW'(1);
        end
        CAPTURE: begin
          byte_cnt <= '0;
          if (ch_tvalid[cur])
            sample_reg <= (SB*8)'(ch_tdata[cur*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
        end
        SERIALIZE: begin
          pay_idx    <= pay_idx + AW'(1);
          sample_reg <= sample_reg >> 8;
          if (byte_cnt == BCW'(SB - 1)) begin
            byte_cnt <= '0;
            if (has_next) cur <= next_ch;
          end else begin
            byte_cnt <= byte_cnt + BCW'(1);
          end
        end
        FINALIZE: begin
          len    <= pay_idx;
          rd_ptr <= '0;
        end
        EMIT: begin
          if (out_load) begin
            pkt_tvalid <= 1'b1;
            if (rd_ptr <= len) begin
              pkt_tdata <= rd_data;
              pkt_tlast <= 1'b0;
              rd_ptr    <= rd_ptr + AW'(1);
            end else begin
              pkt_tdata <= COBS_DELIMITER;
              pkt_tlast <= 1'b1;
            end
          end
        end
        DELIM: begin
          if (pkt_tready) begin
            pkt_tvalid <= 1'b0;
            pkt_tlast  <= 1'b0;
            pkt_tdata  <= '0;
            seq_count  <= seq_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  cobs_encode_buffer #(
    .BUF_DEPTH (BUF_DEPTH),
    .ADDR_W    (AW)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .clear    (buf_clear),
    .wr_en    (wr_en),
    .wr_index (pay_idx),
    .wr_data  (wr_data),
    .fin_en   (fin_en),
    .fin_len  (pay_idx),
    .rd_addr  (rd_ptr),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_xadc_multichannel_packetizer.sv
// Directed bench for the two-channel, 16-bit configuration of the packetizer.
module tb_xadc_multichannel_packetizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  channel_enable = '0;
  logic [31:0] ch_tdata = '0;
  logic [1:0]  ch_tvalid = '0;
  logic [1:0]  ch_tready;
  logic [7:0]  pkt_tdata;
  logic        pkt_tvalid;
  logic        pkt_tready = 1'b1;
  logic        pkt_tlast;
  logic [7:0]  seq_count;

  int checks = 0;
  int failures = 0;

  logic [7:0] got [32];
  logic       got_last [32];
  int         got_n;
  bit         timed_out;
  int         stable_err;
  int         ready_err;

  always #5 clk = ~clk;

  xadc_multichannel_packetizer #(
    .NUM_CHANNELS (2),
    .SAMPLE_WIDTH (16),
    .BUF_DEPTH    (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .channel_enable (channel_enable),
    .ch_tdata       (ch_tdata),
    .ch_tvalid      (ch_tvalid),
    .ch_tready      (ch_tready),
    .pkt_tdata      (pkt_tdata),
    .pkt_tvalid     (pkt_tvalid),
    .pkt_tready     (pkt_tready),
    .pkt_tlast      (pkt_tlast),
    .seq_count      (seq_count)
  );

  // Starts one packet, drops channel_enable after IDLE is left, and records
  // accepted output bytes until tlast or the cycle budget runs out.
  task automatic collect_packet(input logic [1:0] en, input logic [1:0] valid,
                                input logic [15:0] d0, input logic [15:0] d1,
                                input bit rand_ready);
    bit         prev_stall = 0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 0;
    got_n = 0; timed_out = 1; stable_err = 0; ready_err = 0;
    @(negedge clk);
    channel_enable = en;
    ch_tdata = {d1, d0};
    ch_tvalid = valid;
    pkt_tready = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc == 0) channel_enable = '0;
      if (prev_stall && (pkt_tdata !== prev_data || pkt_tvalid !== 1'b1 || pkt_tlast !== prev_last))
        stable_err++;
      if ((ch_tready & ~en) !== 2'b00) ready_err++;
      pkt_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (pkt_tvalid && pkt_tready && got_n < 32) begin
        got[got_n] = pkt_tdata;
        got_last[got_n] = pkt_tlast;
        got_n++;
        if (pkt_tlast) begin
          timed_out = 0;
          break;
        end
      end
      prev_stall = pkt_tvalid && !pkt_tready;
      prev_data = pkt_tdata;
      prev_last = pkt_tlast;
    end
    ch_tvalid = '0;
    @(posedge clk);
    #1;
    pkt_tready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pkt_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tvalid got=%b want=0", pkt_tvalid); end
    checks++; if (pkt_tlast !== 1'b0) begin failures++; $display("[TB] FAIL reset_tlast got=%b want=0", pkt_tlast); end
    checks++; if (pkt_tdata !== 8'h00) begin failures++; $display("[TB] FAIL reset_tdata got=%h want=00", pkt_tdata); end
    checks++; if (seq_count !== 8'h00) begin failures++; $display("[TB] FAIL reset_seq got=%h want=00", seq_count); end
    checks++; if (ch_tready !== 2'b00) begin failures++; $display("[TB] FAIL reset_ready got=%b want=00", ch_tready); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic(input string name, input bit rand_ready);
    logic [7:0] exp [8] = '{8'h01, 8'h06, 8'h03, 8'hFF, 8'h0F, 8'h0F, 8'h7F, 8'h00};
    collect_packet(2'b11, 2'b11, 16'h0FFF, 16'h7F0F, rand_ready);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("[TB] FAIL %s_timeout got=%0d bytes want=8", name, got_n); end
    checks++; if (got_n !== 8) begin failures++; $display("[TB] FAIL %s_len got=%0d want=8", name, got_n); end
    for (int i = 0; i < 8 && i < got_n; i++) begin
      checks++;
      if (got[i] !== exp[i] || got_last[i] !== (i == 7)) begin
        failures++;
        $display("[TB] FAIL %s_byte%0d got=%h/last=%b want=%h/last=%b", name, i, got[i], got_last[i], exp[i], i == 7);
      end
    end
    checks++; if (stable_err !== 0) begin failures++; $display("[TB] FAIL %s_stall_stable got=%0d changes want=0", name, stable_err); end
  endtask

  task automatic test_zero_samples();
    logic [7:0] exp [8] = '{8'h03, 8'h01, 8'h03, 8'h01, 8'h03, 8'h34, 8'h12, 8'h00};
    collect_packet(2'b11, 2'b11, 16'h0000, 16'h1234, 1'b0);
    checks++; if (got_n !== 8 || timed_out !== 1'b0) begin failures++; $display("[TB] FAIL zeros_len got=%0d want=8", got_n); end
    for (int i = 0; i < 8 && i < got_n; i++) begin
      checks++;
      if (got[i] !== exp[i] || got_last[i] !== (i == 7)) begin
        failures++;
        $display("[TB] FAIL zeros_byte%0d got=%h/last=%b want=%h", i, got[i], got_last[i], exp[i]);
      end
    end
    checks++; if (seq_count !== 8'd2) begin failures++; $display("[TB] FAIL zeros_seq got=%0d want=2", seq_count); end
  endtask

  task automatic test_single_channel();
    logic [7:0] exp [6] = '{8'h05, 8'h02, 8'h02, 8'hCD, 8'hAB, 8'h00};
    collect_packet(2'b10, 2'b11, 16'h5555, 16'hABCD, 1'b0);
    checks++; if (got_n !== 6 || timed_out !== 1'b0) begin failures++; $display("[TB] FAIL single_len got=%0d want=6", got_n); end
    for (int i = 0; i < 6 && i < got_n; i++) begin
      checks++;
      if (got[i] !== exp[i] || got_last[i] !== (i == 5)) begin
        failures++;
        $display("[TB] FAIL single_byte%0d got=%h/last=%b want=%h", i, got[i], got_last[i], exp[i]);
      end
    end
    checks++; if (ready_err !== 0) begin failures++; $display("[TB] FAIL single_ch0_ready got=%0d cycles want=0", ready_err); end
  endtask

  task automatic test_seq_wrap();
    int bad_len = 0;
    logic [7:0] b0_255 = '0, b1_255 = '0, b0_256 = '0, b1_256 = '0;
    for (int p = 0; p < 257; p++) begin
      collect_packet(2'b11, 2'b11, 16'h0FFF, 16'h7F0F, 1'b0);
      if (got_n != 8 || timed_out) bad_len++;
      if (p == 255) begin b0_255 = got[0]; b1_255 = got[1]; end
      if (p == 256) begin b0_256 = got[0]; b1_256 = got[1]; end
    end
    checks++; if (bad_len !== 0) begin failures++; $display("[TB] FAIL wrap_lengths got=%0d bad want=0", bad_len); end
    checks++; if (b0_255 !== 8'h07 || b1_255 !== 8'hFF) begin failures++; $display("[TB] FAIL wrap_pkt256 got=%h %h want=07 ff", b0_255, b1_255); end
    checks++; if (b0_256 !== 8'h01 || b1_256 !== 8'h06) begin failures++; $display("[TB] FAIL wrap_pkt257 got=%h %h want=01 06", b0_256, b1_256); end
    checks++; if (seq_count !== 8'd1) begin failures++; $display("[TB] FAIL wrap_seq got=%0d want=1", seq_count); end
  endtask

  task automatic test_reset_mid_emit();
    bit seen = 0;
    @(negedge clk);
    channel_enable = 2'b11;
    ch_tdata = {16'h7F0F, 16'h0FFF};
    ch_tvalid = 2'b11;
    pkt_tready = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      channel_enable = '0;
      if (pkt_tvalid) begin seen = 1; break; end
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL midreset_reach_emit got=%b want=1", seen); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (pkt_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_tvalid got=%b want=0", pkt_tvalid); end
    checks++; if (seq_count !== 8'd0) begin failures++; $display("[TB] FAIL midreset_seq got=%0d want=0", seq_count); end
    ch_tvalid = '0;
    pkt_tready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_basic("after_reset", 1'b0);
  endtask

  task automatic test_disabled_idle();
    int valid_seen = 0;
    int ready_seen = 0;
    @(negedge clk);
    channel_enable = '0;
    ch_tvalid = 2'b11;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (pkt_tvalid !== 1'b0) valid_seen++;
      if (ch_tready !== 2'b00) ready_seen++;
    end
    ch_tvalid = '0;
    checks++; if (valid_seen !== 0) begin failures++; $display("[TB] FAIL idle_output got=%0d cycles want=0", valid_seen); end
    checks++; if (ready_seen !== 0) begin failures++; $display("[TB] FAIL idle_ready got=%0d cycles want=0", ready_seen); end
  endtask

  initial begin
    test_reset();
    test_basic("basic", 1'b0);
    test_zero_samples();
    test_single_channel();
    test_reset();
    test_basic("backpressure", 1'b1);
    test_reset();
    test_seq_wrap();
    test_reset_mid_emit();
    test_disabled_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xadc_multichannel_packetizer.md
Name: xadc_multichannel_packetizer

Overview:
Parametrised successor to the two-channel XADC packetizer. It collects one sample from each enabled AXIS sample channel and prepends a sequence byte and a channel-mask byte. The frame is COBS-encoded in place in a local buffer and emitted as an 8-bit AXIS byte stream, terminated by a 0x00 delimiter with tlast. It sits between the XADC DRP/AXIS adapter and the UART/USB byte transport.

Parameters:
NUM_CHANNELS, 2, number of sample channels (1..8).
SAMPLE_WIDTH, 16, bits per sample (1..32); each sample is zero-extended to SAMPLE_BYTES = ceil(SAMPLE_WIDTH/8) bytes.
BUF_DEPTH, 64, encode buffer depth in bytes. Must be >= 3 + NUM_CHANNELS*SAMPLE_BYTES. Elaboration assertion.

Ports:
clk  in  1  single clock.
reset  in  1  asynchronous, active-high reset.
channel_enable  in  NUM_CHANNELS  bit i enables channel i; sampled on leaving IDLE.
ch_tdata  in  NUM_CHANNELS*SAMPLE_WIDTH  channel i occupies bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH].
ch_tvalid  in  NUM_CHANNELS  per-channel valid.
ch_tready  out  NUM_CHANNELS  per-channel ready.
pkt_tdata  out  8  encoded byte.
pkt_tvalid  out  1  encoded byte valid.
pkt_tready  in  1  downstream ready.
pkt_tlast  out  1  high on the 0x00 delimiter byte only.
seq_count  out  8  sequence number of the next packet (debug).

Behaviour:
- Reset (async assert, sync release): state IDLE; ch_tready=0; pkt_tvalid=0; pkt_tlast=0; pkt_tdata=0; seq_count=0; buffer contents don't-care.
- Payload byte order: seq, mask (zero-extended to 8 bits), then samples of enabled channels in ascending index order, each little-endian (LSB first). Payload length L = 2 + popcount(mask)*SAMPLE_BYTES.
- In-place COBS: buffer slot 0 is the overhead code; payload byte k is written at slot k+1. Register last_code_pos starts at 0.
  - If byte k is 0x00: write buf[last_code_pos] = (k+1) - last_code_pos, then last_code_pos = k+1.
  - Otherwise: write the byte to slot k+1.
  - Finalize writes buf[last_code_pos] = (L+1) - last_code_pos.
  - One buffer write per cycle.
- State machine:
  - IDLE: if channel_enable != 0, latch mask, clear last_code_pos, go to HEADER. If channel_enable == 0, stay in IDLE and emit nothing.
  - HEADER: 2 cycles, writing seq then mask. Go to CAPTURE at the lowest enabled channel.
  - CAPTURE: ch_tready[cur]=1 only while waiting, all other bits 0. On handshake, latch the sample, drop ready, go to SERIALIZE.
  - SERIALIZE: SAMPLE_BYTES cycles, writing 1 byte/cycle. Then go to the next enabled channel (CAPTURE), or to FINALIZE after the last one.
  - FINALIZE: 1 cycle writing the end code. Go to EMIT.
  - EMIT: present buf[0..L] in order, advancing on pkt_tvalid && pkt_tready. Then go to DELIM.
  - DELIM: present 0x00 with pkt_tlast=1. On handshake, seq_count += 1 (wraps 255->0). Go to IDLE.
- pkt_tdata, pkt_tvalid and pkt_tlast are registered. Output holds stable under backpressure: no change while pkt_tvalid && !pkt_tready.
- No capture overlaps emission: ch_tready=0 in all states except CAPTURE.
- Disabled channels are never readied; they are not drained.
- Output length per packet is L+2 bytes. No encoded byte other than the delimiter is 0x00.
- channel_enable changes mid-packet are ignored until the next IDLE.
- Reset mid-packet aborts immediately; the partial packet is lost and seq_count returns to 0.

Decomposition:
- xadc_packet_package gets: COBS_DELIMITER=8'h00, packetizer state enum, helper function sample_bytes(width).
- One sub-module, cobs_encode_buffer: owns the byte RAM, last_code_pos and the code-write logic.
  - Interface: byte-write with payload index, finalize strobe, read address/data.
  - The FSM stays in the top module.

Test Plan:
- NUM_CHANNELS=2, SAMPLE_WIDTH=16, mask=2'b11, seq=0, ch0=0x0FFF, ch1=0x7F0F -> bytes 01 06 03 FF 0F 0F 7F 00; tlast on the 8th byte only.
- Next packet: seq=1, ch0=0x0000, ch1=0x1234 -> 03 01 03 01 03 34 12 00 (consecutive zeros in payload).
- mask=2'b10, seq=2, ch1=0xABCD, ch0 tvalid held high -> 05 02 02 CD AB 00; ch_tready[0] never asserted.
- pkt_tready toggled randomly (~50% duty) during the first scenario -> identical byte sequence; tdata/tvalid/tlast stable while stalled.
- Run 257 packets -> sequence byte wraps 0xFF->0x00; seq_count=1 after the 257th delimiter.
- Assert reset mid-EMIT -> pkt_tvalid drops asynchronously; the next packet starts with seq=0 and is correctly framed; channel_enable=0 -> no output for 1000 cycles.
